// File: rtl/uart_if.sv
// Host-side byte interface of the uart: transmit request/accept and receive holding register.
// master = host driving requests, slave = uart block.
interface uart_if;
  logic       wr_en;
  logic [7:0] din;
  logic       wr_rdy;
  logic       rd_en;
  logic [7:0] dout;
  logic       rd_rdy;

  modport master (
    output wr_en, din, rd_en,
    input  wr_rdy, dout, rd_rdy
  );

  modport slave (
    input  wr_en, din, rd_en,
    output wr_rdy, dout, rd_rdy
  );
endinterface

// File: rtl/uart.sv
// Full-duplex 8N1 UART: one transmitter, one receiver and a single-byte receive holding register.
// Define UART_PARITY_EN to insert and check an even parity bit between data and stop (11-bit frame).
module uart #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  uart_if.slave bus,
  input  logic  rx,
  output logic  tx
);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] RdyLast  = CntW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------- transmitter ----------------
  state_e          tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q = 1'b1;
  logic            tx_d;
  logic            wr_rdy_q = 1'b1;
  logic            wr_rdy_d;
`ifdef UART_PARITY_EN
  logic            tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CntW'(1);
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    wr_rdy_d   = wr_rdy_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (bus.wr_en && wr_rdy_q) begin
          tx_state_d = StStart;
          tx_shift_d = bus.din;
          tx_d       = 1'b0;
          wr_rdy_d   = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = ^bus.din;
`endif
        end
      end
      StStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_state_d = StData;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      StData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_d = StParity;
            tx_d       = tx_par_q;
`else
            tx_state_d = StStop;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (tx_cnt_q == BitLast) begin
          tx_state_d = StStop;
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
        end
      end
`endif
      StStop: begin
        // Ready one cycle early so a held wr_en starts the next frame with no gap.
        if (tx_cnt_q == RdyLast) begin
          tx_state_d = StIdle;
          wr_rdy_d   = 1'b1;
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      wr_rdy_q   <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      wr_rdy_q   <= wr_rdy_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // ---------------- receiver ----------------
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  state_e          rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      dout_q = 8'h00;
  logic [7:0]      dout_d;
  logic            rd_rdy_q = 1'b0;
  logic            rd_rdy_d;
`ifdef UART_PARITY_EN
  logic            rx_perr_q, rx_perr_d;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CntW'(1);
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    dout_d     = dout_q;
    rd_rdy_d   = rd_rdy_q;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    if (!bus.rd_en) begin
      rx_state_d = StIdle;
      rx_cnt_d   = '0;
      rd_rdy_d   = 1'b0;
    end else begin
      unique case (rx_state_q)
        StIdle: begin
          rx_cnt_d = '0;
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_d = StStart;
            rd_rdy_d   = 1'b0;
          end
        end
        StStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_d   = '0;
            rx_idx_d   = '0;
            rx_state_d = rx_s2_q ? StIdle : StData;
          end
        end
        StData: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_idx_d   = rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state_d = StParity;
`else
              rx_state_d = StStop;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        StParity: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_d   = '0;
            rx_perr_d  = rx_s2_q ^ (^rx_shift_q);
            rx_state_d = StStop;
          end
        end
`endif
        StStop: begin
          if (rx_cnt_q == BitLast) begin
            rx_state_d = StIdle;
`ifdef UART_PARITY_EN
            if (rx_s2_q && !rx_perr_q) begin
`else
            if (rx_s2_q) begin
`endif
              dout_d   = rx_shift_q;
              rd_rdy_d = 1'b1;
            end
          end
        end
        default: rx_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      dout_q     <= 8'h00;
      rd_rdy_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      dout_q     <= dout_d;
      rd_rdy_q   <= rd_rdy_d;
`ifdef UART_PARITY_EN
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign bus.wr_rdy = wr_rdy_q;
  assign bus.dout   = dout_q;
  assign bus.rd_rdy = rd_rdy_q;
endmodule

// File: tb/tb_uart.sv
// Bench for uart: two cross-connected instances plus a directly driven rx line for B.
// Expected frames and receive outcomes come from a frame-level model of the serial protocol.
module tb_uart;
  localparam int C = 16;
`ifdef UART_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_if a_bus ();
  uart_if b_bus ();
  logic a_tx, b_tx, b_rx;
  logic rx_drv = 1'b1;
  logic rx_sel = 1'b0;
  assign b_rx = rx_sel ? rx_drv : a_tx;

  uart #(.CLKS_PER_BIT(C)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_bus), .rx(b_tx), .tx(a_tx));
  uart #(.CLKS_PER_BIT(C)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_bus), .rx(b_rx), .tx(b_tx));

  int checks = 0;
  int fails = 0;
  int t0;
  logic [7:0] mdl_dout;
  logic       mdl_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial bit k of a frame, in wire order.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic stop,
                                             input logic pflip);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_PARITY_EN
    f[9]   = (^d) ^ pflip;
    f[10]  = stop;
`else
    f[9]   = stop;
`endif
    return f;
  endfunction

  task automatic send_a(input logic [7:0] d);
    for (int i = 0; i < NBits * C + 4 && !a_bus.wr_rdy; i++) @(negedge clk);
    @(negedge clk);
    a_bus.din   = d;
    a_bus.wr_en = 1'b1;
    @(posedge clk);
    #1;
    t0          = cyc;
    a_bus.wr_en = 1'b0;
  endtask

  task automatic wait_rdy_b(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (b_bus.rd_rdy) break;
    end
  endtask

  task automatic clear_b(input string tag);
    @(negedge clk);
    b_bus.rd_en = 1'b0;
    @(posedge clk);
    #1;
    check(tag, 32'(b_bus.rd_rdy), 32'(1'b0));
    b_bus.rd_en = 1'b1;
    mdl_rdy     = 1'b0;
  endtask

  // Drives one frame onto B's rx; drop_at >= 0 removes rd_en from that bit to the frame end.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input logic pflip,
                             input int drop_at);
    logic [10:0] f;
    logic        valid;
    f     = frame_bits(d, stop, pflip);
    valid = f[NBits-1];
`ifdef UART_PARITY_EN
    valid = valid && ((^f[9:1]) == 1'b0);
`endif
    for (int k = 0; k < NBits; k++) begin
      @(negedge clk);
      rx_drv = f[k];
      if (k == drop_at) b_bus.rd_en = 1'b0;
      repeat (C - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_drv      = 1'b1;
    b_bus.rd_en = 1'b1;
    mdl_rdy     = valid && (drop_at < 0);
    if (mdl_rdy) mdl_dout = d;
    repeat (C) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    logic [7:0]  d;
    int          lat;
    int          acc[$];
    logic [7:0]  got[$];
    logic        pw, pr;

    a_bus.wr_en = 1'b0; a_bus.din = 8'h00; a_bus.rd_en = 1'b1;
    b_bus.wr_en = 1'b0; b_bus.din = 8'h00; b_bus.rd_en = 1'b1;
    mdl_dout = 8'h00;
    mdl_rdy  = 1'b0;

    // Time zero, before any reset edge.
    #1;
    check("t0_dout", 32'(b_bus.dout), 32'(8'h00));
    check("t0_tx", 32'(a_tx), 32'(1'b1));
    check("t0_wr_rdy", 32'(a_bus.wr_rdy), 32'(1'b1));
    check("t0_rd_rdy", 32'(b_bus.rd_rdy), 32'(1'b0));

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx", 32'(b_tx), 32'(1'b1));
    check("rst_wr_rdy", 32'(b_bus.wr_rdy), 32'(1'b1));
    check("rst_rd_rdy", 32'(b_bus.rd_rdy), 32'(1'b0));
    check("rst_dout", 32'(b_bus.dout), 32'(8'h00));

    // Directed loopback with bit-by-bit tx check and latency window.
    send_a(8'b1110_1000);
    f = frame_bits(8'b1110_1000, 1'b1, 1'b0);
    for (int k = 0; k < NBits; k++) begin
      repeat (k == 0 ? C / 2 : C) @(posedge clk);
      #1;
      check($sformatf("tx_bit%0d", k), 32'(a_tx), 32'(f[k]));
    end
    wait_rdy_b(3 * C);
    lat = cyc - t0;
    check("lb_rd_rdy", 32'(b_bus.rd_rdy), 32'(1'b1));
    check("lb_dout", 32'(b_bus.dout), 32'(8'hE8));
    check("lb_latency", 32'(lat >= (NBits - 1) * C + 3 && lat <= NBits * C + 3), 32'(1'b1));
    repeat (2 * C) @(posedge clk);
    #1;
    check("hold_rd_rdy", 32'(b_bus.rd_rdy), 32'(1'b1));
    check("hold_dout", 32'(b_bus.dout), 32'(8'hE8));

    // Random bytes A -> B.
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom);
      clear_b("rnd_clear");
      send_a(d);
      wait_rdy_b(NBits * C + 8);
      check("rnd_rd_rdy", 32'(b_bus.rd_rdy), 32'(1'b1));
      check("rnd_dout", 32'(b_bus.dout), 32'(d));
    end

    // Simultaneous transfer in both directions.
    for (int i = 0; i < NBits * C + 4 && !a_bus.wr_rdy; i++) @(negedge clk);
    clear_b("bi_clear");
    @(negedge clk);
    a_bus.rd_en = 1'b0;
    @(negedge clk);
    a_bus.rd_en = 1'b1;
    a_bus.din = 8'h55; a_bus.wr_en = 1'b1;
    b_bus.din = 8'hA3; b_bus.wr_en = 1'b1;
    @(posedge clk);
    #1;
    a_bus.wr_en = 1'b0;
    b_bus.wr_en = 1'b0;
    for (int i = 0; i < NBits * C + 8; i++) begin
      @(posedge clk);
      #1;
      if (a_bus.rd_rdy && b_bus.rd_rdy) break;
    end
    check("bi_b_rd_rdy", 32'(b_bus.rd_rdy), 32'(1'b1));
    check("bi_b_dout", 32'(b_bus.dout), 32'(8'h55));
    check("bi_a_rd_rdy", 32'(a_bus.rd_rdy), 32'(1'b1));
    check("bi_a_dout", 32'(a_bus.dout), 32'(8'hA3));
    mdl_dout = 8'h55;

    // Hand-driven frames on B's rx.
    for (int i = 0; i < NBits * C + 4 && !a_bus.wr_rdy; i++) @(negedge clk);
    rx_sel = 1'b1;
    clear_b("fe_clear");
    drive_frame(8'h3C, 1'b0, 1'b0, -1);
    check("fe_rd_rdy", 32'(b_bus.rd_rdy), 32'(mdl_rdy));
    check("fe_dout", 32'(b_bus.dout), 32'(mdl_dout));
    drive_frame(8'h3C, 1'b1, 1'b0, -1);
    check("fe_ok_rd_rdy", 32'(b_bus.rd_rdy), 32'(mdl_rdy));
    check("fe_ok_dout", 32'(b_bus.dout), 32'(mdl_dout));
`ifdef UART_PARITY_EN
    drive_frame(8'hC3, 1'b1, 1'b1, -1);
    check("par_rd_rdy", 32'(b_bus.rd_rdy), 32'(mdl_rdy));
    check("par_dout", 32'(b_bus.dout), 32'(mdl_dout));
`endif
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom);
      drive_frame(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      check("rndf_rd_rdy", 32'(b_bus.rd_rdy), 32'(mdl_rdy));
      check("rndf_dout", 32'(b_bus.dout), 32'(mdl_dout));
    end

    // Short low glitch must not start a reception.
    drive_frame(8'h81, 1'b1, 1'b0, -1);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat ($urandom_range(1, C / 2 - 1)) @(negedge clk);
    rx_drv  = 1'b1;
    mdl_rdy = 1'b0;
    repeat (NBits * C + C) @(negedge clk);
    check("glitch_rd_rdy", 32'(b_bus.rd_rdy), 32'(mdl_rdy));
    check("glitch_dout", 32'(b_bus.dout), 32'(mdl_dout));

    // rd_en removed mid-frame aborts the frame.
    drive_frame(8'h5A, 1'b1, 1'b0, 4);
    check("abort_rd_rdy", 32'(b_bus.rd_rdy), 32'(mdl_rdy));
    check("abort_dout", 32'(b_bus.dout), 32'(mdl_dout));
    drive_frame(8'hA5, 1'b1, 1'b0, -1);
    check("post_abort_dout", 32'(b_bus.dout), 32'(mdl_dout));
    rx_sel = 1'b0;

    // Back-to-back frames with wr_en held.
    clear_b("b2b_clear");
    @(negedge clk);
    a_bus.din   = 8'hFF;
    a_bus.wr_en = 1'b1;
    pw = 1'b1;
    pr = b_bus.rd_rdy;
    for (int i = 0; i < 2 * NBits * C + 4 * C; i++) begin
      @(posedge clk);
      #1;
      if (pw && !a_bus.wr_rdy) begin
        acc.push_back(cyc);
        if (acc.size() == 1) a_bus.din = 8'h00;
        else a_bus.wr_en = 1'b0;
      end
      if (!pr && b_bus.rd_rdy) got.push_back(b_bus.dout);
      pw = a_bus.wr_rdy;
      pr = b_bus.rd_rdy;
    end
    a_bus.wr_en = 1'b0;
    check("b2b_frames", 32'(acc.size()), 32'(2));
    check("b2b_gap", 32'(acc.size() >= 2 ? acc[1] - acc[0] : -1), 32'(NBits * C));
    check("b2b_rx_count", 32'(got.size()), 32'(2));
    check("b2b_first", 32'(got.size() > 0 ? got[0] : 8'hxx), 32'(8'hFF));
    check("b2b_second", 32'(got.size() > 1 ? got[1] : 8'hxx), 32'(8'h00));

    // Reset in the middle of a frame.
    send_a(8'h3E);
    repeat (3 * C) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", 32'(a_tx), 32'(1'b1));
    check("rstmid_wr_rdy", 32'(a_bus.wr_rdy), 32'(1'b1));
    check("rstmid_dout", 32'(b_bus.dout), 32'(8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    send_a(8'h96);
    wait_rdy_b(NBits * C + 8);
    check("rstmid_after_dout", 32'(b_bus.dout), 32'(8'h96));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
